// File: rtl/noc_client_pkg.sv
// rtl/noc_client_pkg.sv - shared constants, types and helpers for the NoC traffic client
//
// Purpose: LFSR taps, payload field offsets, client FSM states and width helpers
// used by noc_traffic_client and noc_vc_token_bucket.
// Ports: none (package).
package noc_client_pkg;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback is the
  // parity of bits 0, 2, 3 and 5, inserted at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Payload layout, LSB first: seq (16 bits), vc, source y, source x.
  localparam int SEQ_FIELD_W = 16;
  localparam int SEQ_LSB     = 0;
  localparam int VC_LSB      = SEQ_LSB + SEQ_FIELD_W;

  function automatic int y_lsb(int vc_w);
    return VC_LSB + vc_w;
  endfunction

  function automatic int x_lsb(int vc_w, int y_w);
    return VC_LSB + vc_w + y_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } state_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2_sat(int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/noc_vc_token_bucket.sv
// rtl/noc_vc_token_bucket.sv - per-VC (SIGMA, RATE) token bucket rate shaper
//
// Purpose: holds up to SIGMA tokens, adds one every RATE cycles (saturating),
// removes one per consume. A refill and a consume in the same cycle cancel.
// Ports:
//   clk             in  clock
//   rst             in  synchronous active-high reset (bucket full, timer 0)
//   consume         in  take one token this cycle (only issued when available)
//   token_available out at least one token held
module noc_vc_token_bucket
  import noc_client_pkg::*;
#(
  parameter int SIGMA = 3,
  parameter int RATE  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic consume,
  output logic token_available
);

  localparam int CNT_W = clog2_sat(SIGMA + 1);
  localparam int TMR_W = clog2_sat(RATE);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(SIGMA);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RATE - 1);

  logic [CNT_W-1:0] tokens_q, tokens_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             refill;

  always_comb begin
    refill   = (timer_q == TMR_LAST);
    timer_d  = refill ? '0 : timer_q + 1'b1;
    tokens_d = tokens_q;
    if (refill && !consume && (tokens_q != FULL)) begin
      tokens_d = tokens_q + 1'b1;
    end else if (consume && !refill) begin
      tokens_d = tokens_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tokens_q <= FULL;
      timer_q  <= '0;
    end else begin
      tokens_q <= tokens_d;
      timer_q  <= timer_d;
    end
  end

  assign token_available = (tokens_q != '0);

endmodule

// File: rtl/noc_traffic_client.sv
// rtl/noc_traffic_client.sv - multi-VC rate-shaped NoC traffic generator and sink
//
// Purpose: injects N_PACKETS packets from mesh node (X, Y) over N_VC = 1<<VC_W
// virtual channels, each shaped by its own token bucket, with round-robin VC
// choice and LFSR destinations; counts ejected packets.
// Optional feature: define NOC_CLIENT_RX_CHECK_EN to build the sticky ejected
// address check driving err; otherwise err is tied to 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_v, i_ack                injection valid / router accept
//   i_vc, i_x, i_y, i_data    injected VC, destination, payload
//   i_b                       one-hot VC of the in-flight packet (0 when idle)
//   o_v, o_x, o_y, o_data     ejected packet (always accepted)
//   rx_count                  ejected packets received
//   err                       sticky ejected address mismatch
//   done                      all packets acknowledged
module noc_traffic_client
  import noc_client_pkg::*;
#(
  parameter int          D_W       = 32,
  parameter int          VC_W      = 2,
  parameter int          X_W       = 2,
  parameter int          Y_W       = 2,
  parameter int          X         = 0,
  parameter int          Y         = 0,
  parameter int          N_PACKETS = 128,
  parameter int          SIGMA     = 3,
  parameter int          RATE      = 20,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 i_v,
  input  logic                 i_ack,
  output logic [VC_W-1:0]      i_vc,
  output logic [X_W-1:0]       i_x,
  output logic [Y_W-1:0]       i_y,
  output logic [D_W-1:0]       i_data,
  output logic [(1<<VC_W)-1:0] i_b,
  input  logic                 o_v,
  input  logic [X_W-1:0]       o_x,
  input  logic [Y_W-1:0]       o_y,
  input  logic [D_W-1:0]       o_data,
  output logic [31:0]          rx_count,
  output logic                 err,
  output logic                 done
);

  localparam int N_VC  = 1 << VC_W;
  localparam int SEQ_W = clog2_sat(N_PACKETS + 1);
  localparam int Y_LSB = y_lsb(VC_W);
  localparam int X_LSB = x_lsb(VC_W, Y_W);
  localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(N_PACKETS);
  localparam logic [X_W-1:0]   OWN_X    = X_W'(X);
  localparam logic [Y_W-1:0]   OWN_Y    = Y_W'(Y);

  state_e            state_q, state_d;
  logic [VC_W-1:0]   rr_q, rr_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [VC_W-1:0]   i_vc_q, i_vc_d;
  logic [X_W-1:0]    i_x_q, i_x_d;
  logic [Y_W-1:0]    i_y_q, i_y_d;
  logic [D_W-1:0]    i_data_q, i_data_d;
  logic [31:0]       rx_count_q, rx_count_d;

  logic [N_VC-1:0]   tok_avail;
  logic [N_VC-1:0]   consume;
  logic [VC_W-1:0]   pick_vc;
  logic [VC_W-1:0]   cand;
  logic              found;
  logic              can_go;
  logic              launch;

  for (genvar g = 0; g < N_VC; g++) begin : g_bucket
    noc_vc_token_bucket #(
      .SIGMA(SIGMA),
      .RATE (RATE)
    ) u_bucket (
      .clk            (clk),
      .rst            (rst),
      .consume        (consume[g]),
      .token_available(tok_avail[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    lfsr_d   = lfsr_q;
    seq_d    = seq_q;
    i_vc_d   = i_vc_q;
    i_x_d    = i_x_q;
    i_y_d    = i_y_q;
    i_data_d = i_data_q;
    consume  = '0;
    pick_vc  = rr_q;
    cand     = rr_q;
    found    = 1'b0;

    // First eligible VC scanning upward from the round-robin pointer.
    for (int i = 0; i < N_VC; i++) begin
      cand = rr_q + VC_W'(i);
      if (!found && tok_avail[cand] && (seq_q < LAST_SEQ)) begin
        found   = 1'b1;
        pick_vc = cand;
      end
    end

    can_go = (state_q == IDLE) || ((state_q == SEND) && i_ack);
    launch = can_go && found;

    if (launch) begin
      consume[pick_vc] = 1'b1;
      rr_d   = pick_vc + 1'b1;
      lfsr_d = lfsr_next(lfsr_q);
      seq_d  = seq_q + 1'b1;
      i_vc_d = pick_vc;
      i_x_d  = lfsr_d[X_W-1:0];
      i_y_d  = lfsr_d[X_W+Y_W-1:X_W];
      // Never address ourselves: nudge the column.
      if ((i_x_d == OWN_X) && (i_y_d == OWN_Y)) begin
        i_x_d = i_x_d + 1'b1;
      end
      i_data_d = '0;
      i_data_d[X_LSB +: X_W]           = OWN_X;
      i_data_d[Y_LSB +: Y_W]           = OWN_Y;
      i_data_d[VC_LSB +: VC_W]         = pick_vc;
      i_data_d[SEQ_LSB +: SEQ_FIELD_W] = SEQ_FIELD_W'(seq_q);
    end

    case (state_q)
      IDLE:    if (launch) state_d = SEND;
      SEND:    if (i_ack && !launch) state_d = (seq_q == LAST_SEQ) ? FIN : IDLE;
      FIN:     state_d = FIN;
      default: state_d = IDLE;
    endcase

    rx_count_d = rx_count_q + {31'd0, o_v};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      lfsr_q     <= SEED;
      seq_q      <= '0;
      i_vc_q     <= '0;
      i_x_q      <= '0;
      i_y_q      <= '0;
      i_data_q   <= '0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lfsr_q     <= lfsr_d;
      seq_q      <= seq_d;
      i_vc_q     <= i_vc_d;
      i_x_q      <= i_x_d;
      i_y_q      <= i_y_d;
      i_data_q   <= i_data_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Ejected payload bits outside the source field are never inspected.
  logic unused_rx;
  assign unused_rx = ^{o_x, o_y, o_data};

`ifdef NOC_CLIENT_RX_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (o_v && ((o_x != OWN_X) || (o_y != OWN_Y) ||
                ((o_data[X_LSB +: X_W] == OWN_X) && (o_data[Y_LSB +: Y_W] == OWN_Y)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    i_b = '0;
    if (state_q == SEND) i_b[i_vc_q] = 1'b1;
  end

  assign i_v      = (state_q == SEND);
  assign done     = (state_q == FIN);
  assign i_vc     = i_vc_q;
  assign i_x      = i_x_q;
  assign i_y      = i_y_q;
  assign i_data   = i_data_q;
  assign rx_count = rx_count_q;

endmodule

// File: tb/tb_noc_traffic_client.sv
// tb/tb_noc_traffic_client.sv - randomized self-checking bench for noc_traffic_client
module tb_noc_traffic_client;

  localparam int D_W = 32, VC_W = 2, X_W = 2, Y_W = 2, X = 1, Y = 1;
  localparam int N_PACKETS = 20, SIGMA = 3, RATE = 20;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int N_VC = 1 << VC_W, X_MAX = 1 << X_W, Y_MAX = 1 << Y_W;
  localparam int YL = 16 + VC_W, XL = 16 + VC_W + Y_W;
`ifdef NOC_CLIENT_RX_CHECK_EN
  localparam bit RX_CHECK = 1'b1;
`else
  localparam bit RX_CHECK = 1'b0;
`endif

  logic            clk, rst;
  logic            i_v, i_ack;
  logic [VC_W-1:0] i_vc;
  logic [X_W-1:0]  i_x;
  logic [Y_W-1:0]  i_y;
  logic [D_W-1:0]  i_data;
  logic [N_VC-1:0] i_b;
  logic            o_v;
  logic [X_W-1:0]  o_x;
  logic [Y_W-1:0]  o_y;
  logic [D_W-1:0]  o_data;
  logic [31:0]     rx_count;
  logic            err, done;

  noc_traffic_client #(
    .D_W(D_W), .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .X(X), .Y(Y),
    .N_PACKETS(N_PACKETS), .SIGMA(SIGMA), .RATE(RATE), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_ack(i_ack), .i_vc(i_vc), .i_x(i_x),
    .i_y(i_y), .i_data(i_data), .i_b(i_b), .o_v(o_v), .o_x(o_x), .o_y(o_y),
    .o_data(o_data), .rx_count(rx_count), .err(err), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, passed = 0, dut_acks = 0;

  // Reference model: cycle count since reset drives refills, tokens are plain ints.
  int m_tok[N_VC];
  int m_cyc, m_rr, m_seq, m_vc, m_x, m_y, m_data, m_rx;
  bit m_iv, m_done, m_err;
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic fb;
    // Taps x^16, x^14, x^13, x^11 map to bits 16-16, 16-14, 16-13, 16-11.
    fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
    return {fb, s[15:1]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_VC; c++) m_tok[c] = SIGMA;
    m_cyc = 0; m_rr = 0; m_seq = 0; m_vc = 0; m_x = 0; m_y = 0; m_data = 0; m_rx = 0;
    m_iv = 0; m_done = 0; m_err = 0; m_lfsr = SEED;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; i_ack = 1'b0; o_v = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".i_v"}, i_v, 0);
    chk({tag, ".i_b"}, i_b, 0);
    chk({tag, ".fields"}, {i_vc, i_x, i_y, i_data}, 0);
    chk({tag, ".rx_count"}, rx_count, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".done"}, done, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Predict the next edge from the inputs now driven, take the edge, compare.
  task automatic step();
    bit ack, launch;
    int v, refill, t;
    if (i_v && i_ack) dut_acks++;
    ack = m_iv && i_ack;
    launch = 0; v = 0;
    if ((!m_iv || i_ack) && !m_done && m_seq < N_PACKETS) begin
      for (int k = 0; k < N_VC; k++) begin
        if (!launch && m_tok[(m_rr + k) % N_VC] > 0) begin
          launch = 1; v = (m_rr + k) % N_VC;
        end
      end
    end
    refill = (m_cyc % RATE == RATE - 1) ? 1 : 0;
    for (int c = 0; c < N_VC; c++) begin
      t = m_tok[c] + refill - ((launch && c == v) ? 1 : 0);
      m_tok[c] = (t > SIGMA) ? SIGMA : t;
    end
    if (launch) begin
      m_lfsr = lfsr_adv(m_lfsr);
      m_x = int'(m_lfsr) % X_MAX;
      m_y = (int'(m_lfsr) / X_MAX) % Y_MAX;
      if (m_x == X && m_y == Y) m_x = (m_x + 1) % X_MAX;
      m_vc = v;
      m_data = m_seq + (v << 16) + (Y << YL) + (X << XL);
      m_seq++;
      m_rr = (v + 1) % N_VC;
      m_iv = 1;
    end else if (ack) begin
      m_iv = 0;
      if (m_seq == N_PACKETS) m_done = 1;
    end
    if (o_v) begin
      m_rx++;
      if (RX_CHECK && (int'(o_x) != X || int'(o_y) != Y ||
                       (int'(o_data[XL +: X_W]) == X && int'(o_data[YL +: Y_W]) == Y)))
        m_err = 1;
    end
    m_cyc++;
    @(posedge clk); #1;
    chk("i_v", i_v, m_iv);
    chk("i_b", i_b, m_iv ? (64'd1 << m_vc) : 64'd0);
    chk("done", done, m_done);
    chk("rx_count", rx_count, 64'(m_rx));
    chk("err", err, m_err);
    if (m_iv) begin
      chk("i_vc", i_vc, 64'(m_vc));
      chk("i_x", i_x, 64'(m_x));
      chk("i_y", i_y, 64'(m_y));
      chk("i_data", i_data, 64'(m_data));
      chk("noself", (int'(i_x) == X) && (int'(i_y) == Y), 0);
    end
  endtask

  initial begin
    int extra;
    rst = 1'b1; i_ack = 1'b0; o_v = 1'b0; o_x = '0; o_y = '0; o_data = '0;
    do_reset("reset");

    // First packet held under backpressure for 10 cycles.
    repeat (11) step();
    chk("first_seq", i_data[15:0], 0);

    // Random acks and ejections until well after completion.
    extra = 0;
    for (int n = 0; n < 1500 && extra < 5; n++) begin
      if (m_done) extra++;
      i_ack  = ($urandom_range(0, 3) != 0);
      o_v    = 1'($urandom_range(0, 1));
      o_x    = X_W'(X);
      o_y    = Y_W'(Y);
      o_data = $urandom;
      if ($urandom_range(0, 7) == 0) o_x = X_W'($urandom_range(0, X_MAX - 1));
      step();
    end
    chk("done_reached", done, 1);
    chk("ack_count", 64'(dut_acks), N_PACKETS);

    // Misaddressed ejection, then reset while a packet is held.
    do_reset("reset2");
    i_ack = 1'b0; o_v = 1'b1; o_x = X_W'((X + 1) % X_MAX); o_y = Y_W'(Y); o_data = '0;
    step();
    chk("rx_one", rx_count, 1);
    chk("err_set", err, RX_CHECK);
    o_v = 1'b0;
    repeat (4) step();
    chk("err_sticky", err, RX_CHECK);
    chk("mid_send", i_v, 1);
    do_reset("reset_mid_send");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
